// File: rtl/riscv_lsu_if.sv
// Core-side and memory-side signal bundle for the load/store unit.
// The LSU connects through the slave modport; the core/memory environment uses master.
interface riscv_lsu_if;
    logic        core_req_i;
    logic        core_we_i;
    logic [2:0]  core_size_i;
    logic [31:0] core_addr_i;
    logic [31:0] core_wd_i;
    logic [31:0] core_rd_o;
    logic        core_stall_o;
    logic        core_err_o;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wd_o;
    logic [31:0] mem_rd_i;
    logic        mem_ready_i;

    modport slave (
        input  core_req_i, core_we_i, core_size_i, core_addr_i, core_wd_i,
        input  mem_rd_i, mem_ready_i,
        output core_rd_o, core_stall_o, core_err_o,
        output mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wd_o
    );

    modport master (
        output core_req_i, core_we_i, core_size_i, core_addr_i, core_wd_i,
        output mem_rd_i, mem_ready_i,
        input  core_rd_o, core_stall_o, core_err_o,
        input  mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wd_o
    );
endinterface

// File: rtl/riscv_lsu.sv
// RISC-V load/store unit: one outstanding access, byte-lane steering for stores,
// sign/zero extension for loads, one-cycle error pulse for misaligned/invalid requests.
module riscv_lsu (
    input  logic        clk,
    input  logic        rst,
    riscv_lsu_if.slave  bus
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]  state;
    logic        err_q;
    logic [2:0]  size_q;
    logic [1:0]  off_q;

    logic        mem_req_q;
    logic        mem_we_q;
    logic [3:0]  mem_be_q;
    logic [31:0] mem_addr_q;
    logic [31:0] mem_wd_q;
    logic [31:0] core_rd_q;

    logic        size_ok;
    logic        aligned;
    logic [3:0]  be_next;
    logic [31:0] wd_next;
    logic [31:0] load_data;
    logic [31:0] rd_shift;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    always_comb begin
        size_ok = 1'b0;
        aligned = 1'b0;
        case (bus.core_size_i)
            3'b000, 3'b100: begin size_ok = 1'b1; aligned = 1'b1;                        end
            3'b001, 3'b101: begin size_ok = 1'b1; aligned = ~bus.core_addr_i[0];         end
            3'b010:         begin size_ok = 1'b1; aligned = (bus.core_addr_i[1:0] == 2'b00); end
            default: ;
        endcase
    end

    // Stores replicate the datum across all lanes; be selects which lanes the memory commits.
    always_comb begin
        case (bus.core_size_i[1:0])
            2'b00: begin
                be_next = 4'b0001 << bus.core_addr_i[1:0];
                wd_next = {4{bus.core_wd_i[7:0]}};
            end
            2'b01: begin
                be_next = 4'b0011 << {bus.core_addr_i[1], 1'b0};
                wd_next = {2{bus.core_wd_i[15:0]}};
            end
            default: begin
                be_next = 4'b1111;
                wd_next = bus.core_wd_i;
            end
        endcase
        if (!bus.core_we_i) be_next = '0;
    end

    always_comb begin
        rd_shift = bus.mem_rd_i >> {off_q, 3'b000};
        ld_byte  = rd_shift[7:0];
        ld_half  = off_q[1] ? bus.mem_rd_i[31:16] : bus.mem_rd_i[15:0];
        case (size_q)
            3'b000:  load_data = {{24{ld_byte[7]}}, ld_byte};
            3'b100:  load_data = {24'd0, ld_byte};
            3'b001:  load_data = {{16{ld_half[15]}}, ld_half};
            3'b101:  load_data = {16'd0, ld_half};
            default: load_data = bus.mem_rd_i;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            err_q      <= 1'b0;
            size_q     <= '0;
            off_q      <= '0;
            mem_req_q  <= 1'b0;
            mem_we_q   <= 1'b0;
            mem_be_q   <= '0;
            mem_addr_q <= '0;
            mem_wd_q   <= '0;
            core_rd_q  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.core_req_i) begin
                        if (size_ok && aligned) begin
                            mem_we_q   <= bus.core_we_i;
                            size_q     <= bus.core_size_i;
                            off_q      <= bus.core_addr_i[1:0];
                            mem_addr_q <= {bus.core_addr_i[31:2], 2'b00};
                            mem_be_q   <= be_next;
                            mem_wd_q   <= wd_next;
                            mem_req_q  <= 1'b1;
                            state      <= BUSY;
                        end else begin
                            err_q      <= 1'b1;
                            core_rd_q  <= '0;
                            state      <= DONE;
                        end
                    end
                end
                BUSY: begin
                    if (bus.mem_ready_i) begin
                        mem_req_q <= 1'b0;
                        if (!mem_we_q) core_rd_q <= load_data;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    err_q <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.mem_req_o    = mem_req_q;
    assign bus.mem_we_o     = mem_we_q;
    assign bus.mem_be_o     = mem_be_q;
    assign bus.mem_addr_o   = mem_addr_q;
    assign bus.mem_wd_o     = mem_wd_q;
    assign bus.core_rd_o    = core_rd_q;
    assign bus.core_err_o   = (state == DONE) && err_q;
    assign bus.core_stall_o = bus.core_req_i && (state != DONE);

endmodule

// File: tb/tb_riscv_lsu.sv
// Self-checking bench for riscv_lsu: directed vector table, randomized transactions
// against a lane-arithmetic reference model, and hand sequences for reset/abort cases.
module tb_riscv_lsu;

    typedef struct {
        logic        we;
        logic [2:0]  size;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [31:0] rdata;
        int unsigned delay;
        logic        exp_err;
        logic [31:0] exp_addr;
        logic [3:0]  exp_be;
        logic [31:0] exp_wd;
        logic [31:0] exp_rd;
    } txn_t;

    logic clk;
    logic rst;
    riscv_lsu_if bus();

    riscv_lsu dut (.clk(clk), .rst(rst), .bus(bus));

    int unsigned n_tests;
    int unsigned n_fail;
    logic [31:0] last_rd;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, got no finish expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Expected behaviour from lane arithmetic: a size covers nb bytes starting at offset.
    function automatic txn_t model(input logic we, input logic [2:0] size, input logic [31:0] addr,
                                   input logic [31:0] wd, input logic [31:0] rdata,
                                   input int unsigned delay);
        txn_t t;
        int unsigned nb;
        int unsigned off;
        longint unsigned mask;
        longint unsigned val;
        logic valid;
        t.we = we; t.size = size; t.addr = addr; t.wd = wd; t.rdata = rdata; t.delay = delay;
        valid = (size == 3'd0) || (size == 3'd1) || (size == 3'd2) || (size == 3'd4) || (size == 3'd5);
        nb  = (size[1:0] == 2'd0) ? 1 : (size[1:0] == 2'd1) ? 2 : 4;
        off = addr % 4;
        t.exp_err  = !valid || ((off % nb) != 0);
        t.exp_addr = addr - off;
        t.exp_be   = '0;
        t.exp_wd   = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            if (we && i >= off && i < off + nb) t.exp_be[i] = 1'b1;
            t.exp_wd[8*i +: 8] = wd[8*(i % nb) +: 8];
        end
        mask = (64'd1 << (8 * nb)) - 64'd1;
        val  = ({32'd0, rdata} >> (8 * off)) & mask;
        if (!size[2] && nb < 4 && val[8*nb-1]) val = val | ~mask;
        t.exp_rd = t.exp_err ? 32'd0 : val[31:0];
        return t;
    endfunction

    task automatic run_txn(input txn_t t);
        int unsigned stalls;
        logic [31:0] exp_rd;
        stalls = 0;
        @(posedge clk); #1;
        bus.core_req_i  = 1'b1;
        bus.core_we_i   = t.we;
        bus.core_size_i = t.size;
        bus.core_addr_i = t.addr;
        bus.core_wd_i   = t.wd;
        bus.mem_ready_i = 1'b0;
        bus.mem_rd_i    = $urandom;
        @(negedge clk);
        if (bus.core_stall_o) stalls++;
        @(posedge clk); #1;
        if (t.exp_err) begin
            check("err_pulse", {31'd0, bus.core_err_o}, 32'd1);
            check("err_no_mem_req", {31'd0, bus.mem_req_o}, 32'd0);
            check("err_rd_zero", bus.core_rd_o, 32'd0);
            @(negedge clk);
            if (bus.core_stall_o) stalls++;
            check("err_stall_cycles", stalls, 32'd1);
            bus.core_req_i = 1'b0;
            @(posedge clk); #1;
            check("err_pulse_end", {31'd0, bus.core_err_o}, 32'd0);
            last_rd = 32'd0;
        end else begin
            for (int unsigned c = 0; c <= t.delay; c++) begin
                check("busy_req", {31'd0, bus.mem_req_o}, 32'd1);
                check("busy_we", {31'd0, bus.mem_we_o}, {31'd0, t.we});
                check("busy_addr", bus.mem_addr_o, t.exp_addr);
                check("busy_be", {28'd0, bus.mem_be_o}, {28'd0, t.exp_be});
                check("busy_wd", bus.mem_wd_o, t.exp_wd);
                if (c == t.delay) begin
                    bus.mem_ready_i = 1'b1;
                    bus.mem_rd_i    = t.rdata;
                end
                @(negedge clk);
                if (bus.core_stall_o) stalls++;
                @(posedge clk); #1;
            end
            bus.mem_ready_i = 1'b0;
            bus.mem_rd_i    = $urandom;
            exp_rd = t.we ? last_rd : t.exp_rd;
            check("done_req_low", {31'd0, bus.mem_req_o}, 32'd0);
            check("done_no_err", {31'd0, bus.core_err_o}, 32'd0);
            check("done_rd", bus.core_rd_o, exp_rd);
            @(negedge clk);
            if (bus.core_stall_o) stalls++;
            check("stall_cycles", stalls, t.delay + 2);
            bus.core_req_i = 1'b0;
            last_rd = exp_rd;
        end
    endtask

    task automatic idle_noise(input int unsigned cycles);
        for (int unsigned c = 0; c < cycles; c++) begin
            @(posedge clk); #1;
            bus.mem_ready_i = 1'($urandom_range(0, 1));
            bus.mem_rd_i    = $urandom;
            @(negedge clk);
            check("idle_no_req", {31'd0, bus.mem_req_o}, 32'd0);
            check("idle_rd_hold", bus.core_rd_o, last_rd);
        end
        @(posedge clk); #1;
        bus.mem_ready_i = 1'b0;
    endtask

    txn_t tbl[12];
    txn_t rt;
    logic [2:0] rsize;
    logic [31:0] raddr;
    logic [2:0] valid_sizes[5];

    initial begin
        n_tests = 0;
        n_fail  = 0;
        last_rd = 32'd0;
        valid_sizes = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};

        //          we    size  addr          wd            rdata         dly err  exp_addr      be       exp_wd        exp_rd
        tbl[0]  = '{1'b0, 3'd2, 32'h0000_0010, 32'h0,       32'hDEAD_BEEF, 0, 1'b0, 32'h0000_0010, 4'b0000, 32'h0,        32'hDEAD_BEEF};
        tbl[1]  = '{1'b0, 3'd0, 32'h0000_0013, 32'h0,       32'h80FF_0000, 0, 1'b0, 32'h0000_0010, 4'b0000, 32'h0,        32'hFFFF_FF80};
        tbl[2]  = '{1'b0, 3'd4, 32'h0000_0013, 32'h0,       32'h80FF_0000, 1, 1'b0, 32'h0000_0010, 4'b0000, 32'h0,        32'h0000_0080};
        tbl[3]  = '{1'b1, 3'd1, 32'h0000_0022, 32'h1234_ABCD, 32'h0,       0, 1'b0, 32'h0000_0020, 4'b1100, 32'hABCD_ABCD, 32'h0};
        tbl[4]  = '{1'b0, 3'd2, 32'h0000_0006, 32'h0,       32'h0,         0, 1'b1, 32'h0,         4'b0000, 32'h0,        32'h0};
        tbl[5]  = '{1'b1, 3'd2, 32'h0000_0040, 32'hCAFE_F00D, 32'h0,       5, 1'b0, 32'h0000_0040, 4'b1111, 32'hCAFE_F00D, 32'h0};
        tbl[6]  = '{1'b0, 3'd1, 32'h0000_0002, 32'h0,       32'h8001_1234, 0, 1'b0, 32'h0000_0000, 4'b0000, 32'h0,        32'hFFFF_8001};
        tbl[7]  = '{1'b0, 3'd5, 32'h0000_0002, 32'h0,       32'h8001_1234, 2, 1'b0, 32'h0000_0000, 4'b0000, 32'h0,        32'h0000_8001};
        tbl[8]  = '{1'b1, 3'd0, 32'h0000_0041, 32'h0000_0055, 32'h0,       0, 1'b0, 32'h0000_0040, 4'b0010, 32'h5555_5555, 32'h0};
        tbl[9]  = '{1'b0, 3'd1, 32'h0000_0003, 32'h0,       32'h0,         0, 1'b1, 32'h0,         4'b0000, 32'h0,        32'h0};
        tbl[10] = '{1'b1, 3'd3, 32'h0000_0000, 32'hFFFF_FFFF, 32'h0,       0, 1'b1, 32'h0,         4'b0000, 32'h0,        32'h0};
        tbl[11] = '{1'b0, 3'd0, 32'h0000_0000, 32'h0,       32'h0000_007F, 0, 1'b0, 32'h0000_0000, 4'b0000, 32'h0,        32'h0000_007F};

        rst = 1'b0;
        bus.core_req_i  = 1'b0;
        bus.core_we_i   = 1'b0;
        bus.core_size_i = 3'd0;
        bus.core_addr_i = 32'd0;
        bus.core_wd_i   = 32'd0;
        bus.mem_rd_i    = 32'd0;
        bus.mem_ready_i = 1'b0;
        #3;
        check("rst_mem_req", {31'd0, bus.mem_req_o}, 32'd0);
        check("rst_mem_we", {31'd0, bus.mem_we_o}, 32'd0);
        check("rst_mem_be", {28'd0, bus.mem_be_o}, 32'd0);
        check("rst_mem_addr", bus.mem_addr_o, 32'd0);
        check("rst_mem_wd", bus.mem_wd_o, 32'd0);
        check("rst_core_rd", bus.core_rd_o, 32'd0);
        check("rst_core_err", {31'd0, bus.core_err_o}, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;

        for (int unsigned i = 0; i < 12; i++) run_txn(tbl[i]);

        // Core withdraws the request mid-access: the access must still complete.
        @(posedge clk); #1;
        bus.core_req_i = 1'b1; bus.core_we_i = 1'b0; bus.core_size_i = 3'd2;
        bus.core_addr_i = 32'h0000_0008; bus.mem_ready_i = 1'b0;
        @(posedge clk); #1;
        check("drop_busy_req", {31'd0, bus.mem_req_o}, 32'd1);
        bus.core_req_i = 1'b0;
        @(negedge clk);
        check("drop_stall_low", {31'd0, bus.core_stall_o}, 32'd0);
        @(posedge clk); #1;
        check("drop_still_busy", {31'd0, bus.mem_req_o}, 32'd1);
        bus.mem_ready_i = 1'b1; bus.mem_rd_i = 32'h1357_2468;
        @(posedge clk); #1;
        bus.mem_ready_i = 1'b0;
        check("drop_done_req", {31'd0, bus.mem_req_o}, 32'd0);
        check("drop_rd", bus.core_rd_o, 32'h1357_2468);
        last_rd = 32'h1357_2468;

        // Reset asserted in the middle of a BUSY access.
        @(posedge clk); #1;
        bus.core_req_i = 1'b1; bus.core_we_i = 1'b1; bus.core_size_i = 3'd2;
        bus.core_addr_i = 32'h0000_0080; bus.core_wd_i = 32'hA5A5_5A5A;
        @(posedge clk); #1;
        check("rstbusy_req_pre", {31'd0, bus.mem_req_o}, 32'd1);
        #2 rst = 1'b0;
        #1;
        check("rstbusy_req", {31'd0, bus.mem_req_o}, 32'd0);
        check("rstbusy_we", {31'd0, bus.mem_we_o}, 32'd0);
        check("rstbusy_be", {28'd0, bus.mem_be_o}, 32'd0);
        check("rstbusy_addr", bus.mem_addr_o, 32'd0);
        check("rstbusy_wd", bus.mem_wd_o, 32'd0);
        check("rstbusy_rd", bus.core_rd_o, 32'd0);
        bus.core_req_i = 1'b0;
        last_rd = 32'd0;
        @(negedge clk);
        rst = 1'b1;
        rt = model(1'b0, 3'd2, 32'h0000_0044, 32'd0, 32'h0BAD_F00D, 1);
        run_txn(rt);

        for (int unsigned n = 0; n < 60; n++) begin
            if ($urandom_range(0, 3) == 0) rsize = 3'($urandom_range(0, 7));
            else rsize = valid_sizes[$urandom_range(0, 4)];
            raddr = $urandom;
            if ($urandom_range(0, 1) == 1) raddr[1:0] = 2'b00;
            rt = model(1'($urandom_range(0, 1)), rsize, raddr, $urandom, $urandom,
                       $urandom_range(0, 3));
            run_txn(rt);
            idle_noise($urandom_range(0, 2));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
